// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore FSM that sequences a shared-memory multicycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq, jal, lui). One instruction in flight,
// memory accesses stall on MemReady, unsupported opcodes raise IllegalOp.
// Optional build macro: MC_PERF_CNT_EN adds CycleCount/InstrCount counters.
module multicycle_controller #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       RegWrite,
   output logic       IllegalOp
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] CycleCount,
   output logic [CNT_WIDTH-1:0] InstrCount
`endif
);

   // Opcodes handled by this controller
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   // FSM state encodings; codes 12..15 are unused and recover to FETCH
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_LUI      = 4'd11;

   // A zero-width counter would be meaningless
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("multicycle_controller: CNT_WIDTH must be at least 1");
   end

   logic [3:0] state_q;
   logic [3:0] state_d;

   // Un-gated per-state controls; write enables are masked by reset below
   logic pc_update;
   logic branch;
   logic ir_write_raw;
   logic mem_write_raw;
   logic reg_write_raw;
   logic illegal_raw;
   logic op_supported;

   assign op_supported = (op == OP_LW)  || (op == OP_SW)  || (op == OP_R)   ||
                         (op == OP_I)   || (op == OP_BEQ) || (op == OP_JAL) ||
                         (op == OP_LUI);

   // State register: reset returns to FETCH, abandoning any instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; op is looked at only in DECODE and MEMADR
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               state_d = S_MEMREAD;
            end else if (op == OP_SW) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_LUI:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls; anything not set in a state stays 0
   always_comb begin
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
            ir_write_raw = MemReady;
            pc_update    = MemReady;
         end
         S_DECODE: begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b01;
            illegal_raw = ~op_supported;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_LUI: begin
            ResultSrc     = 2'b11;
            reg_write_raw = 1'b1;
         end
         default: begin
            AdrSrc = 1'b0;
         end
      endcase
   end

   // Immediate format select, decoded straight from the opcode
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 3'b001;
         OP_BEQ:  ImmSrc = 3'b010;
         OP_JAL:  ImmSrc = 3'b011;
         OP_LUI:  ImmSrc = 3'b100;
         default: ImmSrc = 3'b000;
      endcase
   end

   // Write enables are forced low while reset is held so nothing partial lands
   assign PCWrite   = ~reset & (pc_update | (branch & Zero));
   assign IRWrite   = ~reset & ir_write_raw;
   assign MemWrite  = ~reset & mem_write_raw;
   assign RegWrite  = ~reset & reg_write_raw;
   assign IllegalOp = ~reset & illegal_raw;

`ifdef MC_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cycle_cnt_q;
   logic [CNT_WIDTH-1:0] cycle_cnt_d;
   logic [CNT_WIDTH-1:0] instr_cnt_q;
   logic [CNT_WIDTH-1:0] instr_cnt_d;

   // Counters wrap naturally at 2^CNT_WIDTH
   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
      instr_cnt_d = IRWrite ? instr_cnt_q + 1'b1 : instr_cnt_q;
   end

   // Performance counters, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign CycleCount = cycle_cnt_q;
   assign InstrCount = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed checks of the multicycle controller: per-cycle output vectors
// for every instruction class, memory stalls, illegal opcode, reset
// mid-instruction, ImmSrc decode, and (with MC_PERF_CNT_EN) the counters.
module tb_multicycle_controller;

   localparam int unsigned TB_CNT_W = 4;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalOp}
   localparam logic [13:0] V_FETCH_GO = 14'b1001_10_00_10_00_0_0;
   localparam logic [13:0] V_FETCH_WT = 14'b0000_10_00_10_00_0_0;
   localparam logic [13:0] V_DECODE   = 14'b0000_00_01_01_00_0_0;
   localparam logic [13:0] V_DEC_ILL  = 14'b0000_00_01_01_00_0_1;
   localparam logic [13:0] V_MEMADR   = 14'b0000_00_10_01_00_0_0;
   localparam logic [13:0] V_MEMREAD  = 14'b0100_00_00_00_00_0_0;
   localparam logic [13:0] V_MEMWB    = 14'b0000_01_00_00_00_1_0;
   localparam logic [13:0] V_MEMWRITE = 14'b0110_00_00_00_00_0_0;
   localparam logic [13:0] V_EXECR    = 14'b0000_00_10_00_10_0_0;
   localparam logic [13:0] V_EXECI    = 14'b0000_00_10_01_10_0_0;
   localparam logic [13:0] V_ALUWB    = 14'b0000_00_00_00_00_1_0;
   localparam logic [13:0] V_BEQ_T    = 14'b1000_00_10_00_01_0_0;
   localparam logic [13:0] V_BEQ_N    = 14'b0000_00_10_00_01_0_0;
   localparam logic [13:0] V_JAL      = 14'b1000_00_01_10_00_0_0;
   localparam logic [13:0] V_LUI      = 14'b0000_11_00_00_00_1_0;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [2:0] ImmSrc;
   logic       RegWrite;
   logic       IllegalOp;
`ifdef MC_PERF_CNT_EN
   logic [TB_CNT_W-1:0] CycleCount;
   logic [TB_CNT_W-1:0] InstrCount;
`endif

   logic [13:0] outs;
   logic [4:0]  wen;
   int          checks;
   int          errors;

   assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUOp, RegWrite, IllegalOp};
   assign wen  = {PCWrite, IRWrite, MemWrite, RegWrite, IllegalOp};

   multicycle_controller #(
      .CNT_WIDTH(TB_CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .Zero      (Zero),
      .MemReady  (MemReady),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .RegWrite  (RegWrite),
      .IllegalOp (IllegalOp)
`ifdef MC_PERF_CNT_EN
      ,
      .CycleCount(CycleCount),
      .InstrCount(InstrCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (wen !== 5'b00000) begin
            errors++;
            $display("FAIL reset_wen cycle %0d: got %b required 00000", i, wen);
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      MemReady = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_FETCH_WT) begin
         errors++;
         $display("FAIL reset_fetch: got %b required %b", outs, V_FETCH_WT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      logic [13:0] exp [$];
      logic        mr [$];
      op = OP_LW; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
      mr  = '{H, H, H, H, H};
      for (int i = 0; i < exp.size(); i++) begin
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL lw_zero_wait cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_stall();
      logic [13:0] exp [$];
      logic        mr [$];
      op = OP_LW; Zero = 1'b1;
      exp = '{V_FETCH_WT, V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD,
              V_MEMREAD, V_MEMREAD, V_MEMWB};
      mr  = '{L, H, H, H, L, L, L, H, H};
      for (int i = 0; i < exp.size(); i++) begin
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL lw_stall cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw();
      logic [13:0] exp [$];
      logic        mr [$];
      op = OP_SW; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE};
      mr  = '{H, H, H, L, L, H};
      for (int i = 0; i < exp.size(); i++) begin
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL sw_stall cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu();
      logic [13:0] exp [$];
      logic [6:0]  ops [$];
      MemReady = 1'b1; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_EXECR, V_ALUWB,
              V_FETCH_GO, V_DECODE, V_EXECI, V_ALUWB};
      ops = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I, OP_I};
      for (int i = 0; i < exp.size(); i++) begin
         op = ops[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL alu_r_i cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_beq();
      logic [13:0] exp [$];
      logic        zq [$];
      op = OP_BEQ; MemReady = 1'b1;
      exp = '{V_FETCH_GO, V_DECODE, V_BEQ_T, V_FETCH_GO, V_DECODE, V_BEQ_N};
      zq  = '{L, L, H, H, H, L};
      for (int i = 0; i < exp.size(); i++) begin
         Zero = zq[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL beq cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jal_lui();
      logic [13:0] exp [$];
      logic [6:0]  ops [$];
      MemReady = 1'b1; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_JAL, V_ALUWB, V_FETCH_GO, V_DECODE, V_LUI};
      ops = '{OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_LUI, OP_LUI, OP_LUI};
      for (int i = 0; i < exp.size(); i++) begin
         op = ops[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL jal_lui cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      logic [13:0] exp [$];
      logic        mr [$];
      op = OP_BAD; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DEC_ILL, V_FETCH_WT};
      mr  = '{H, H, L};
      for (int i = 0; i < exp.size(); i++) begin
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL illegal cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_op_ignored();
      logic [13:0] exp [$];
      logic [6:0]  ops [$];
      logic        mr [$];
      Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD, V_MEMWB, V_FETCH_WT};
      ops = '{OP_LW, OP_LW, OP_LW, OP_BAD, OP_R, OP_BAD, OP_BAD};
      mr  = '{H, H, H, L, H, H, L};
      for (int i = 0; i < exp.size(); i++) begin
         op = ops[i];
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL op_ignored cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_immsrc();
      logic [6:0] ops [$];
      logic [2:0] exp [$];
      MemReady = 1'b0;
      ops = '{OP_LW, OP_I, OP_SW, OP_BEQ, OP_JAL, OP_LUI, OP_R};
      exp = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
      for (int i = 0; i < ops.size(); i++) begin
         op = ops[i];
         #1;
         checks++;
         if (ImmSrc !== exp[i]) begin
            errors++;
            $display("FAIL immsrc op=%b: got %b required %b", ops[i], ImmSrc, exp[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (outs !== V_FETCH_WT) begin
         errors++;
         $display("FAIL immsrc_hold: got %b required %b", outs, V_FETCH_WT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [13:0] exp [$];
      logic        mr [$];
      op = OP_SW; Zero = 1'b0;
      exp = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMWRITE};
      mr  = '{H, H, H, L};
      for (int i = 0; i < exp.size(); i++) begin
         MemReady = mr[i];
         @(negedge clk);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL reset_mid_pre cycle %0d: got %b required %b", i, outs, exp[i]);
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (wen !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_wen: got %b required 00000", wen);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_FETCH_WT) begin
         errors++;
         $display("FAIL reset_mid_fetch: got %b required %b", outs, V_FETCH_WT);
      end
      @(posedge clk); #1;
   endtask

`ifdef MC_PERF_CNT_EN
   task automatic test_perf();
      reset = 1'b1; MemReady = 1'b1; op = OP_R; Zero = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (CycleCount !== 4'd0 || InstrCount !== 4'd0) begin
         errors++;
         $display("FAIL perf_clear: got cyc=%0d ins=%0d required 0 0", CycleCount, InstrCount);
      end
      repeat (12) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (CycleCount !== 4'd12 || InstrCount !== 4'd3) begin
         errors++;
         $display("FAIL perf_three_r: got cyc=%0d ins=%0d required 12 3", CycleCount, InstrCount);
      end
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (CycleCount !== 4'd1 || InstrCount !== 4'd5) begin
         errors++;
         $display("FAIL perf_wrap: got cyc=%0d ins=%0d required 1 5", CycleCount, InstrCount);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      MemReady = 1'b1;
      op = OP_LW;
      Zero = 1'b0;
      test_reset();
      test_lw();
      test_lw_stall();
      test_sw();
      test_alu();
      test_beq();
      test_jal_lui();
      test_illegal();
      test_op_ignored();
      test_immsrc();
      test_reset_mid();
`ifdef MC_PERF_CNT_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
